// File: rtl/i2c_bus_filter.sv
// rtl/i2c_bus_filter.sv - I2C SCL/SDA synchroniser, glitch filter and bus event detector (optional timeout: I2C_FILTER_TIMEOUT_EN)
module i2c_bus_filter #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic busy_o,
  output logic timeout_o
);

  localparam int CW = $clog2(FILTER_LEN) + 1;

  // Out-of-range parameters leave this marker block in the elaborated hierarchy
  if (FILTER_LEN < 2 || FILTER_LEN > 15 || TIMEOUT_CYCLES < 2) begin : g_param_out_of_range
  end

  logic          scl_s1, scl_s2, sda_s1, sda_s2;
  logic          scl_f, sda_f;
  logic          scl_f_nxt, sda_f_nxt;
  logic [CW-1:0] scl_cnt, sda_cnt, scl_cnt_nxt, sda_cnt_nxt;
  logic          busy_clr;

  assign scl_o = scl_f;
  assign sda_o = sda_f;

  // Two-flop synchronisers; reset to the idle (released) bus level
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
    end
  end

  // Stability counters: a new level is accepted after FILTER_LEN consecutive differing samples
  always_comb begin
    scl_f_nxt   = scl_f;
    sda_f_nxt   = sda_f;
    scl_cnt_nxt = '0;
    sda_cnt_nxt = '0;
    if (scl_s2 != scl_f) begin
      if (scl_cnt == CW'(FILTER_LEN - 1)) scl_f_nxt = scl_s2;
      else                                scl_cnt_nxt = scl_cnt + CW'(1);
    end
    if (sda_s2 != sda_f) begin
      if (sda_cnt == CW'(FILTER_LEN - 1)) sda_f_nxt = sda_s2;
      else                                sda_cnt_nxt = sda_cnt + CW'(1);
    end
  end

  // Filtered levels and edge/event strobes, aligned with the first cycle of the new level
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      scl_f      <= 1'b1;
      sda_f      <= 1'b1;
      scl_cnt    <= '0;
      sda_cnt    <= '0;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
    end else begin
      scl_f      <= scl_f_nxt;
      sda_f      <= sda_f_nxt;
      scl_cnt    <= scl_cnt_nxt;
      sda_cnt    <= sda_cnt_nxt;
      scl_rise_o <= ~scl_f & scl_f_nxt;
      scl_fall_o <= scl_f & ~scl_f_nxt;
      // SCL must be high before and after; an SCL change in the same cycle masks the SDA event
      start_o    <= scl_f & scl_f_nxt & sda_f & ~sda_f_nxt;
      stop_o     <= scl_f & scl_f_nxt & ~sda_f & sda_f_nxt;
    end
  end

`ifdef I2C_FILTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [TW-1:0] to_cnt;
  logic          timeout_q;

  // Counts SCL-low cycles while the bus is owned; fires once and frees the bus
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (scl_f || !busy_o) begin
        to_cnt <= '0;
      end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        to_cnt    <= '0;
        timeout_q <= 1'b1;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end
    end
  end

  assign timeout_o = timeout_q;
  assign busy_clr  = stop_o | timeout_q;
`else
  assign timeout_o = 1'b0;
  assign busy_clr  = stop_o;
`endif

  // Bus ownership: set after START (repeated START keeps it), cleared after STOP or timeout
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      busy_o <= 1'b0;
    end else if (start_o) begin
      busy_o <= 1'b1;
    end else if (busy_clr) begin
      busy_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_bus_filter.sv
// tb/tb_i2c_bus_filter.sv - scoreboard bench for i2c_bus_filter
module tb_i2c_bus_filter;

  localparam int LAT = 6;
  localparam logic [4:0] S_RISE = 5'b10000;
  localparam logic [4:0] S_FALL = 5'b01000;
  localparam logic [4:0] S_STRT = 5'b00100;
  localparam logic [4:0] S_STOP = 5'b00010;
  localparam logic [4:0] S_TMO  = 5'b00001;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic scl = 1'b0;
  logic sda = 1'b0;
  logic scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, busy_o, timeout_o;

  i2c_bus_filter #(.FILTER_LEN(4), .TIMEOUT_CYCLES(100)) dut (
    .clk_i      (clk),
    .reset_i    (reset_n),
    .scl_i      (scl),
    .sda_i      (sda),
    .scl_o      (scl_o),
    .sda_o      (sda_o),
    .scl_rise_o (scl_rise_o),
    .scl_fall_o (scl_fall_o),
    .start_o    (start_o),
    .stop_o     (stop_o),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [4:0] stb;
    logic       scl;
    logic       sda;
    logic       busy;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  rise_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected event for an input change made in the current cycle
  task automatic expect_ev(input int extra, input logic [4:0] stb, input logic s, input logic d,
                           input logic b);
    ev_t e;
    e.cyc  = cyc + LAT + extra;
    e.stb  = stb;
    e.scl  = s;
    e.sda  = d;
    e.busy = b;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe cycle is matched against the head of the scoreboard
  initial begin
    ev_t        e;
    logic [4:0] stb;
    forever begin
      @(negedge clk);
      stb = {scl_rise_o, scl_fall_o, start_o, stop_o, timeout_o};
      if (stb != 5'b0) begin
        if (scl_rise_o) rise_count++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got %b at cycle %0d, required none", stb, cyc);
        end else begin
          e = exp_q.pop_front();
          check("strobe_cycle", cyc, e.cyc);
          check("strobe_kind", {27'b0, stb}, {27'b0, e.stb});
          check("scl_o_at_strobe", {31'b0, scl_o}, {31'b0, e.scl});
          check("sda_o_at_strobe", {31'b0, sda_o}, {31'b0, e.sda});
          check("busy_at_strobe", {31'b0, busy_o}, {31'b0, e.busy});
        end
      end
    end
  end

  logic [7:0] byte_val;
  int         rise_base;

  initial begin
    byte_val = 8'hA5;
    // Reset held with both pins low: outputs must stay idle
    reset_n = 1'b0; scl = 1'b0; sda = 1'b0;
    tick(3);
    check("reset_scl_o", {31'b0, scl_o}, 1);
    check("reset_sda_o", {31'b0, sda_o}, 1);
    check("reset_strobes", {27'b0, scl_rise_o, scl_fall_o, start_o, stop_o, timeout_o}, 0);
    check("reset_busy", {31'b0, busy_o}, 0);

    // Release: both lines fall together after 6 cycles, SCL strobe only
    reset_n = 1'b1;
    expect_ev(0, S_FALL, 1'b0, 1'b0, 1'b0);
    tick(LAT - 1);
    check("scl_o_before_latency", {31'b0, scl_o}, 1);
    tick(1);
    check("scl_o_at_latency", {31'b0, scl_o}, 0);
    tick(4);

    // Back to idle, simultaneous rise: SCL strobe only, no STOP
    scl = 1'b1; sda = 1'b1;
    expect_ev(0, S_RISE, 1'b1, 1'b1, 1'b0);
    tick(12);

    // 3-cycle glitch rejected
    scl = 1'b0;
    tick(3);
    scl = 1'b1;
    tick(12);
    check("glitch3_scl_o", {31'b0, scl_o}, 1);

    // 4-cycle pulse accepted
    scl = 1'b0;
    expect_ev(0, S_FALL, 1'b0, 1'b1, 1'b0);
    tick(4);
    scl = 1'b1;
    expect_ev(0, S_RISE, 1'b1, 1'b1, 1'b0);
    tick(12);

    // START then STOP
    sda = 1'b0;
    expect_ev(0, S_STRT, 1'b1, 1'b0, 1'b0);
    tick(LAT);
    check("busy_during_start", {31'b0, busy_o}, 0);
    tick(1);
    check("busy_after_start", {31'b0, busy_o}, 1);
    tick(5);
    sda = 1'b1;
    expect_ev(0, S_STOP, 1'b1, 1'b1, 1'b1);
    tick(LAT);
    check("busy_during_stop", {31'b0, busy_o}, 1);
    tick(1);
    check("busy_after_stop", {31'b0, busy_o}, 0);
    tick(5);

    // START, byte 0xA5, repeated START, STOP
    sda = 1'b0;
    expect_ev(0, S_STRT, 1'b1, 1'b0, 1'b0);
    tick(8);
    rise_base = rise_count;
    for (int i = 7; i >= 0; i--) begin
      scl = 1'b0;
      expect_ev(0, S_FALL, 1'b0, sda, 1'b1);
      tick(8);
      sda = byte_val[i];
      tick(8);
      scl = 1'b1;
      expect_ev(0, S_RISE, 1'b1, byte_val[i], 1'b1);
      tick(8);
      check("busy_in_byte", {31'b0, busy_o}, 1);
    end
    check("byte_rise_count", rise_count - rise_base, 8);
    sda = 1'b0;
    expect_ev(0, S_STRT, 1'b1, 1'b0, 1'b1);
    tick(8);
    check("busy_after_rep_start", {31'b0, busy_o}, 1);
    scl = 1'b0;
    expect_ev(0, S_FALL, 1'b0, 1'b0, 1'b1);
    tick(8);
    scl = 1'b1;
    expect_ev(0, S_RISE, 1'b1, 1'b0, 1'b1);
    tick(8);
    sda = 1'b1;
    expect_ev(0, S_STOP, 1'b1, 1'b1, 1'b1);
    tick(8);
    check("busy_after_byte_stop", {31'b0, busy_o}, 0);

    // Simultaneous SCL rise and SDA fall: no START; then STOP while idle
    scl = 1'b0;
    expect_ev(0, S_FALL, 1'b0, 1'b1, 1'b0);
    tick(8);
    scl = 1'b1; sda = 1'b0;
    expect_ev(0, S_RISE, 1'b1, 1'b0, 1'b0);
    tick(8);
    check("busy_after_simul", {31'b0, busy_o}, 0);
    sda = 1'b1;
    expect_ev(0, S_STOP, 1'b1, 1'b1, 1'b0);
    tick(8);
    check("busy_after_idle_stop", {31'b0, busy_o}, 0);

    // START then SCL held low
    sda = 1'b0;
    expect_ev(0, S_STRT, 1'b1, 1'b0, 1'b0);
    tick(8);
    scl = 1'b0;
    expect_ev(0, S_FALL, 1'b0, 1'b0, 1'b1);
`ifdef I2C_FILTER_TIMEOUT_EN
    expect_ev(100, S_TMO, 1'b0, 1'b0, 1'b1);
    tick(LAT + 100);
    check("busy_at_timeout", {31'b0, busy_o}, 1);
    tick(1);
    check("busy_after_timeout", {31'b0, busy_o}, 0);
    tick(10);
    scl = 1'b1;
    expect_ev(0, S_RISE, 1'b1, 1'b0, 1'b0);
    tick(8);
    sda = 1'b1;
    expect_ev(0, S_STOP, 1'b1, 1'b1, 1'b0);
    tick(8);
`else
    tick(LAT + 110);
    check("busy_held_no_timeout", {31'b0, busy_o}, 1);
    scl = 1'b1;
    expect_ev(0, S_RISE, 1'b1, 1'b0, 1'b1);
    tick(8);
    sda = 1'b1;
    expect_ev(0, S_STOP, 1'b1, 1'b1, 1'b1);
    tick(8);
`endif
    check("busy_final", {31'b0, busy_o}, 0);

    tick(10);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
